// File: rtl/fft_pkg.sv
// fft_pkg: constants and types shared by the FFT front-end blocks.
// FFT_SIZE_DEFAULT is the frame length used when a block is not overridden.
package fft_pkg;

    localparam int FFT_SIZE_DEFAULT = 1024;
    localparam int FFT_AW           = $clog2(FFT_SIZE_DEFAULT);
    localparam int FFT_DATA_W       = 32;

    // One two's-complement sample at the default width.
    typedef logic [FFT_DATA_W-1:0] fft_sample_t;

    // Drain-side sequencer states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } drain_state_e;

endpackage

// File: rtl/fft_framer_half_ram.sv
// fft_framer_half_ram: simple dual-port memory holding one half of one
// frame bank. One write port, one read port with a registered (synchronous)
// read. The read register holds its value while i_rd_en is low.
module fft_framer_half_ram #(
    parameter  int DEPTH  = 512,
    parameter  int DATA_W = 32,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Sample storage write port.
    // NOTE: the array itself is not reset; a reset would turn the RAM into
    // flops. Only the read register below is reset so the outputs start at 0.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Synchronous read; the register holds the last word when not reading.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_input_framer.sv
// fft_input_framer: collects a serial sample stream into ping-pong frame
// banks and replays each complete frame as half-split pairs
// (x[k], x[k+FFT_SIZE/2]) framed by start_o.
// Optional feature macro: FFT_FRAMER_CPLX_EN -- adds s_im_i and the
// imaginary storage; without it the imaginary outputs are tied to 0.
module fft_input_framer #(
    parameter int FFT_SIZE = fft_pkg::FFT_SIZE_DEFAULT,
    parameter int DATA_W   = fft_pkg::FFT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_re_i,
`ifdef FFT_FRAMER_CPLX_EN
    input  logic [DATA_W-1:0] s_im_i,
`endif
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic              fft_idle_i,
    output logic              start_o,
    output logic [DATA_W-1:0] x0_re_o,
    output logic [DATA_W-1:0] x0_im_o,
    output logic [DATA_W-1:0] x1_re_o,
    output logic [DATA_W-1:0] x1_im_o,
    output logic              frame_drop_o
);

    import fft_pkg::*;

    localparam int AW   = $clog2(FFT_SIZE);
    localparam int HW   = AW - 1;
    localparam int HALF = FFT_SIZE / 2;
    localparam logic [AW-1:0] W_LAST = AW'(FFT_SIZE - 1);
    localparam logic [HW-1:0] K_LAST = HW'(HALF - 1);

    // Fill side
    logic [AW-1:0] r_w;
    logic          r_wb;
    logic [1:0]    r_full;
    logic [1:0]    w_full_next;
    logic          w_xfer;
    logic          w_frame_done;

    // Drain side
    drain_state_e  r_state;
    logic          r_rb;
    logic [HW-1:0] r_k;
    logic          r_start;
    logic          r_out_bank;
    logic          w_drain_done;
    logic          w_reading;

    // Readback from the four (or eight) half memories, indexed [bank][half].
    logic [DATA_W-1:0] w_rd_re [2][2];

    // Ready depends only on registered state, never on s_valid_i.
    assign s_ready_o    = !r_full[r_wb];
    assign w_xfer       = s_valid_i && s_ready_o;
    assign w_frame_done = w_xfer && (r_w == W_LAST);
    assign w_reading    = (r_state == ST_RUN);
    assign w_drain_done = w_reading && (r_k == K_LAST);

    // Write index and write bank advance on every accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w  <= '0;
            r_wb <= 1'b0;
        end else if (w_xfer) begin
            if (w_frame_done) begin
                r_w  <= '0;
                r_wb <= ~r_wb;
            end else begin
                r_w <= r_w + 1'b1;
            end
        end
    end

    // Bank-full flags: the fill side sets, the drain side clears. They never
    // target the same bank in one cycle, so both updates are applied.
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, which rules out latch inference.
    always_comb begin
        w_full_next = r_full;
        if (w_drain_done) begin
            w_full_next[r_rb] = 1'b0;
        end
        if (w_frame_done) begin
            w_full_next[r_wb] = 1'b1;
        end
    end

    // Register the full flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= '0;
        end else begin
            r_full <= w_full_next;
        end
    end

    // Drain sequencer: waits for a full bank and an idle FFT core, then
    // replays N/2 pairs with start_o high. fft_idle_i is only looked at in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rb    <= 1'b0;
            r_k     <= '0;
            r_start <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_full[r_rb] && fft_idle_i) begin
                        r_state <= ST_RUN;
                        r_k     <= '0;
                        r_start <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_k == K_LAST) begin
                        r_state <= ST_IDLE;
                        r_rb    <= ~r_rb;
                        r_start <= 1'b0;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    // Remember which bank the RAM read registers were last loaded from, so the
    // outputs keep showing the last pair after the replay ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_bank <= 1'b0;
        end else if (w_reading) begin
            r_out_bank <= r_rb;
        end
    end

`ifdef FFT_FRAMER_CPLX_EN
    logic [DATA_W-1:0] w_rd_im [2][2];
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar h = 0; h < 2; h++) begin : g_half
            logic w_wr_en;
            logic w_rd_en;

            // Index MSB selects lower/upper half; the rest is the address.
            assign w_wr_en = w_xfer && (r_wb == 1'(b)) && (r_w[AW-1] == 1'(h));
            assign w_rd_en = w_reading && (r_rb == 1'(b));

            fft_framer_half_ram #(
                .DEPTH  (HALF),
                .DATA_W (DATA_W)
            ) u_re (
                .clk       (clk),
                .rst       (rst),
                .i_wr_en   (w_wr_en),
                .i_wr_addr (r_w[HW-1:0]),
                .i_wr_data (s_re_i),
                .i_rd_en   (w_rd_en),
                .i_rd_addr (r_k),
                .o_rd_data (w_rd_re[b][h])
            );

`ifdef FFT_FRAMER_CPLX_EN
            fft_framer_half_ram #(
                .DEPTH  (HALF),
                .DATA_W (DATA_W)
            ) u_im (
                .clk       (clk),
                .rst       (rst),
                .i_wr_en   (w_wr_en),
                .i_wr_addr (r_w[HW-1:0]),
                .i_wr_data (s_im_i),
                .i_rd_en   (w_rd_en),
                .i_rd_addr (r_k),
                .o_rd_data (w_rd_im[b][h])
            );
`endif
        end
    end

    assign start_o      = r_start;
    assign x0_re_o      = w_rd_re[r_out_bank][0];
    assign x1_re_o      = w_rd_re[r_out_bank][1];
`ifdef FFT_FRAMER_CPLX_EN
    assign x0_im_o      = w_rd_im[r_out_bank][0];
    assign x1_im_o      = w_rd_im[r_out_bank][1];
`else
    assign x0_im_o      = '0;
    assign x1_im_o      = '0;
`endif
    // Backpressure means a frame is never lost, so this is reserved.
    assign frame_drop_o = 1'b0;

endmodule

// File: tb/tb_fft_input_framer.sv
// tb_fft_input_framer: directed + randomized bench for fft_input_framer with
// FFT_SIZE=8. A queue-based reference model tracks accepted samples, complete
// frames and the replay in progress, and predicts every output each cycle.
module tb_fft_input_framer;

    localparam int N  = 8;
    localparam int H  = N / 2;
    localparam int DW = 32;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic [DW-1:0] s_re_i     = '0;
`ifdef FFT_FRAMER_CPLX_EN
    logic [DW-1:0] s_im_i     = '0;
`endif
    logic          s_valid_i  = 1'b0;
    logic          fft_idle_i = 1'b0;
    logic          s_ready_o;
    logic          start_o;
    logic          frame_drop_o;
    logic [DW-1:0] x0_re_o, x0_im_o, x1_re_o, x1_im_o;

    fft_input_framer #(
        .FFT_SIZE (N),
        .DATA_W   (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_re_i       (s_re_i),
`ifdef FFT_FRAMER_CPLX_EN
        .s_im_i       (s_im_i),
`endif
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .fft_idle_i   (fft_idle_i),
        .start_o      (start_o),
        .x0_re_o      (x0_re_o),
        .x0_im_o      (x0_im_o),
        .x1_re_o      (x1_re_o),
        .x1_im_o      (x1_im_o),
        .frame_drop_o (frame_drop_o)
    );

    always #5 clk = ~clk;

    // Reference model: complete frames waiting or replaying (front first),
    // the partial frame being filled, and cycles left in the current replay.
    logic [DW-1:0] fr_re[$], fr_im[$], pa_re[$], pa_im[$];
    int            run_left = 0;
    logic [DW-1:0] e_x0re = '0, e_x1re = '0, e_x0im = '0, e_x1im = '0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fr_re.delete(); fr_im.delete(); pa_re.delete(); pa_im.delete();
        run_left = 0;
        e_x0re = '0; e_x1re = '0; e_x0im = '0; e_x1im = '0;
    endtask

    task automatic check_outputs();
        check("start_o",      DW'(start_o),      DW'(run_left > 0));
        check("s_ready_o",    DW'(s_ready_o),    DW'(fr_re.size() < 2 * N));
        check("frame_drop_o", DW'(frame_drop_o), '0);
        check("x0_re_o",      x0_re_o,           e_x0re);
        check("x1_re_o",      x1_re_o,           e_x1re);
        check("x0_im_o",      x0_im_o,           e_x0im);
        check("x1_im_o",      x1_im_o,           e_x1im);
    endtask

    // One clock: predict the edge, let it happen, compare 1 time unit later.
    task automatic step(output bit xfer);
        bit drained;
        int k;
        drained = 1'b0;
        xfer    = s_valid_i && (fr_re.size() < 2 * N);
        @(posedge clk);
        if (run_left > 0) begin
            k      = H - run_left;
            e_x0re = fr_re[k];
            e_x1re = fr_re[k + H];
`ifdef FFT_FRAMER_CPLX_EN
            e_x0im = fr_im[k];
            e_x1im = fr_im[k + H];
`endif
            run_left--;
            drained = (run_left == 0);
        end else if (fr_re.size() >= N && fft_idle_i) begin
            run_left = H;
        end
        if (drained) begin
            repeat (N) begin
                void'(fr_re.pop_front());
`ifdef FFT_FRAMER_CPLX_EN
                void'(fr_im.pop_front());
`endif
            end
        end
        if (xfer) begin
            pa_re.push_back(s_re_i);
`ifdef FFT_FRAMER_CPLX_EN
            pa_im.push_back(s_im_i);
`endif
            if (pa_re.size() == N) begin
                fr_re = {fr_re, pa_re};
                fr_im = {fr_im, pa_im};
                pa_re.delete();
                pa_im.delete();
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        bit x;
        s_valid_i = 1'b0;
        repeat (n) step(x);
    endtask

    // Feed one frame base..base+N-1 (imag = negated real); gappy toggles valid.
    task automatic feed_frame(input logic [DW-1:0] base, input bit gappy);
        bit x;
        int cnt;
        cnt = 0;
        for (int cyc = 0; cyc < 200 && cnt < N; cyc++) begin
            s_valid_i = !gappy || (cyc % 2 == 0);
            s_re_i    = base + DW'(cnt);
`ifdef FFT_FRAMER_CPLX_EN
            s_im_i    = -(base + DW'(cnt));
`endif
            step(x);
            if (x) cnt++;
        end
        s_valid_i = 1'b0;
        check("feed_count", DW'(cnt), DW'(N));
    endtask

    // Reset asserted between edges; start_o must drop without a clock.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        check_outputs();
    endtask

    initial begin
        bit x;
        int waited;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check_outputs();

        // Ramp, continuous input, FFT idle
        fft_idle_i = 1'b1;
        feed_frame(32'd0, 1'b0);
        idle_cycles(8);

        // Gappy input, same frame
        feed_frame(32'd0, 1'b1);
        idle_cycles(8);

        // Backpressure: FFT busy, three frames offered
        fft_idle_i = 1'b0;
        feed_frame(32'd200, 1'b0);
        feed_frame(32'd300, 1'b0);
        s_valid_i = 1'b1;
        s_re_i    = 32'd400;
`ifdef FFT_FRAMER_CPLX_EN
        s_im_i    = -32'd400;
`endif
        repeat (6) step(x);
        check("bp_ready_low", DW'(s_ready_o), '0);
        fft_idle_i = 1'b1;
        feed_frame(32'd400, 1'b0);
        idle_cycles(30);

        // Reset in the middle of a replay at k=2
        feed_frame(32'd50, 1'b0);
        waited = 0;
        while (run_left != H - 2 && waited < 20) begin
            step(x);
            waited++;
        end
        check("reach_k2", DW'(run_left), DW'(H - 2));
        async_reset();
        feed_frame(32'd100, 1'b0);
        idle_cycles(8);

        // Randomized traffic with random FFT availability
        s_re_i = $urandom;
        for (int i = 0; i < 800; i++) begin
            s_valid_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) fft_idle_i = ~fft_idle_i;
            step(x);
            if (x) begin
                s_re_i = $urandom;
`ifdef FFT_FRAMER_CPLX_EN
                s_im_i = $urandom;
`endif
            end
        end
        fft_idle_i = 1'b1;
        idle_cycles(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
